hls_run_sequencer: RTL and testbench

HLS_RUN_SEQUENCER -- requirements
Module: hls_run_sequencer

---
 rtl/hls_run_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_hls_run_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer.sv
// Purpose : sequences repeated DUT runs (reset, start, wait for done) and keeps per-campaign latency results.
// Latency : a run takes RST_CYCLES reset cycles, one start cycle, then the DUT latency, plus one RECORD cycle.
// Backpressure: none; go is ignored while busy, done_port is ignored outside START/WAIT.
//
// Optional feature macro: HLS_RUN_SEQUENCER_STATS_EN
//   defined   -> min_cycles / max_cycles / total_cycles are kept
//   undefined -> those three outputs are tied to 0 and no statistic registers exist
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   go                  : campaign request; num_runs / timeout_cycles latched on acceptance
//   num_runs            : runs per campaign (0 = finish immediately)
//   timeout_cycles      : per-run cycle limit (0 = no limit)
//   done_port           : DUT completion strobe
//   dut_reset           : reset to the DUT (high during reset and in RST)
//   start_port          : one-cycle DUT start pulse
//   busy/finished       : campaign active / one-cycle end-of-campaign pulse
//   timed_out           : sticky, set when a run hits its limit
//   runs_done           : completed runs in the current campaign
//   last/min/max/total_cycles : run latency results
module hls_run_sequencer #(
  parameter int CNT_W      = 32,
  parameter int RUN_W      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [RUN_W-1:0] num_runs,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic             done_port,
  output logic             dut_reset,
  output logic             start_port,
  output logic             busy,
  output logic             finished,
  output logic             timed_out,
  output logic [RUN_W-1:0] runs_done,
  output logic [CNT_W-1:0] last_cycles,
  output logic [CNT_W-1:0] min_cycles,
  output logic [CNT_W-1:0] max_cycles,
  output logic [CNT_W-1:0] total_cycles
);

  localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    START,
    WAIT,
    RECORD,
    FIN,
    TOUT
  } state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] num_runs_q, num_runs_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [RUN_W-1:0] runs_done_q, runs_done_d;
  logic             timed_out_q, timed_out_d;
  logic [CNT_W-1:0] last_q, last_d;

  // Count including the current cycle; cnt_q holds the count of the previous
  // cycle, so the done_port cycle is part of the latency.
  logic [CNT_W-1:0] cur_cnt;
  logic [RUN_W-1:0] runs_inc;

  assign cur_cnt  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
  assign runs_inc = runs_done_q + RUN_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      num_runs_q  <= '0;
      timeout_q   <= '0;
      runs_done_q <= '0;
      timed_out_q <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      num_runs_q  <= num_runs_d;
      timeout_q   <= timeout_d;
      runs_done_q <= runs_done_d;
      timed_out_q <= timed_out_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cnt_d       = cnt_q;
    num_runs_d  = num_runs_q;
    timeout_d   = timeout_q;
    runs_done_d = runs_done_q;
    timed_out_d = timed_out_q;
    last_d      = last_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          if (num_runs != '0) begin
            num_runs_d  = num_runs;
            timeout_d   = timeout_cycles;
            runs_done_d = '0;
            timed_out_d = 1'b0;
            last_d      = '0;
            rst_cnt_d   = '0;
            state_d     = RST;
          end else begin
            // Empty campaign: report completion, leave every result alone.
            state_d = FIN;
          end
        end
      end

      RST: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d = START;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end

      START: begin
        cnt_d   = CNT_W'(1);
        state_d = done_port ? RECORD : WAIT;
      end

      WAIT: begin
        cnt_d = cur_cnt;
        if (done_port) begin
          // Completion wins over a timeout landing in the same cycle.
          state_d = RECORD;
        end else if ((timeout_q != '0) && (cur_cnt >= timeout_q)) begin
          // >= rather than == so a limit of 1 (already passed in START)
          // still ends the run on the first WAIT cycle.
          state_d = TOUT;
        end
      end

      RECORD: begin
        last_d      = cnt_q;
        runs_done_d = runs_inc;
        rst_cnt_d   = '0;
        state_d     = (runs_inc == num_runs_q) ? FIN : RST;
      end

      TOUT: begin
        timed_out_d = 1'b1;
        state_d     = FIN;
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dut_reset   = reset | (state_q == RST);
  assign start_port  = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign finished    = (state_q == FIN);
  assign timed_out   = timed_out_q;
  assign runs_done   = runs_done_q;
  assign last_cycles = last_q;

`ifdef HLS_RUN_SEQUENCER_STATS_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W:0]   total_sum;
  logic             stat_clr;
  logic             stat_rec;

  assign stat_clr  = (state_q == IDLE) && go && (num_runs != '0);
  assign stat_rec  = (state_q == RECORD);
  assign total_sum = {1'b0, total_q} + {1'b0, cnt_q};

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    total_d = total_q;
    if (stat_clr) begin
      min_d   = CNT_MAX;
      max_d   = '0;
      total_d = '0;
    end else if (stat_rec) begin
      if (cnt_q < min_q) min_d = cnt_q;
      if (cnt_q > max_q) max_d = cnt_q;
      total_d = total_sum[CNT_W] ? CNT_MAX : total_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      min_q   <= CNT_MAX;
      max_q   <= '0;
      total_q <= '0;
    end else begin
      min_q   <= min_d;
      max_q   <= max_d;
      total_q <= total_d;
    end
  end

  assign min_cycles   = min_q;
  assign max_cycles   = max_q;
  assign total_cycles = total_q;
`else
  assign min_cycles   = '0;
  assign max_cycles   = '0;
  assign total_cycles = '0;
`endif

endmodule

// File: tb/tb_hls_run_sequencer.sv
module tb_hls_run_sequencer;

  localparam int RST_CYC = 2;

  logic        clock;
  logic        reset;
  logic        go;
  logic [7:0]  num_runs;
  logic [31:0] timeout_cycles;
  logic        done_port;
  logic        dut_reset, start_port, busy, finished, timed_out;
  logic [7:0]  runs_done;
  logic [31:0] last_cycles, min_cycles, max_cycles, total_cycles;

  // Narrow-counter instance for saturation behaviour.
  logic        s_go;
  logic [7:0]  s_num;
  logic [3:0]  s_tmo;
  logic        s_done;
  logic        s_dut_reset, s_start, s_busy, s_finished, s_timed_out;
  logic [7:0]  s_runs;
  logic [3:0]  s_last, s_min, s_max, s_total;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] last;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [31:0] tot;
    logic [7:0]  runs;
    logic        tout;
  } exp_t;

  exp_t sb[$];

  hls_run_sequencer #(.CNT_W(32), .RUN_W(8), .RST_CYCLES(RST_CYC)) u_dut (
    .clock(clock), .reset(reset), .go(go), .num_runs(num_runs),
    .timeout_cycles(timeout_cycles), .done_port(done_port),
    .dut_reset(dut_reset), .start_port(start_port), .busy(busy),
    .finished(finished), .timed_out(timed_out), .runs_done(runs_done),
    .last_cycles(last_cycles), .min_cycles(min_cycles),
    .max_cycles(max_cycles), .total_cycles(total_cycles)
  );

  hls_run_sequencer #(.CNT_W(4), .RUN_W(8), .RST_CYCLES(RST_CYC)) u_small (
    .clock(clock), .reset(reset), .go(s_go), .num_runs(s_num),
    .timeout_cycles(s_tmo), .done_port(s_done),
    .dut_reset(s_dut_reset), .start_port(s_start), .busy(s_busy),
    .finished(s_finished), .timed_out(s_timed_out), .runs_done(s_runs),
    .last_cycles(s_last), .min_cycles(s_min),
    .max_cycles(s_max), .total_cycles(s_total)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pushes the model's result for the campaign, plays the DUT side, then
  // pops and compares once finished is seen. A latency of 0 means done_port
  // is never raised for that run.
  task automatic do_campaign(input int n, input logic [31:0] tmo,
                             input int l0, input int l1, input int l2,
                             input bit poke);
    int          lat[3];
    exp_t        e;
    logic [32:0] tot;
    logic [31:0] mn, mx;
    int          rc, guard, off;
    lat    = '{l0, l1, l2};
    e.last = 0; e.runs = 0; e.tout = 1'b0;
    mn = 32'hFFFF_FFFF; mx = 0; tot = 0;
    for (int i = 0; i < n; i++) begin
      if (lat[i] == 0 || (tmo != 0 && lat[i] > tmo)) begin
        e.tout = 1'b1;
        break;
      end
      e.last = lat[i];
      e.runs = e.runs + 8'd1;
      if (lat[i] < mn) mn = lat[i];
      if (lat[i] > mx) mx = lat[i];
      tot = tot + 33'(lat[i]);
      if (tot[32]) tot = 33'h0_FFFF_FFFF;
    end
`ifdef HLS_RUN_SEQUENCER_STATS_EN
    e.mn = mn; e.mx = mx; e.tot = tot[31:0];
`else
    e.mn = 0; e.mx = 0; e.tot = 0;
`endif
    sb.push_back(e);

    go = 1'b1; num_runs = 8'(n); timeout_cycles = tmo;
    tick();
    go = 1'b0;

    for (int i = 0; i < n; i++) begin
      rc = 0; guard = 0;
      while (!start_port && guard < 100) begin
        if (dut_reset) rc++;
        tick();
        guard++;
      end
      chk("start_seen", start_port, 1);
      chk("rst_len", rc, RST_CYC);
      if (lat[i] == 0) begin
        off = 0;
        while (!finished && off < 200) begin
          tick();
          off++;
        end
        chk("tout_offset", off, tmo + 1);
        break;
      end
      if (poke && i == 0) begin
        go = 1'b1; num_runs = 8'(n + 4);
      end
      for (int k = 0; k < lat[i] - 1; k++) begin
        tick();
        go = 1'b0;
      end
      done_port = 1'b1;
      tick();
      done_port = 1'b0;
      go = 1'b0;
    end

    guard = 0;
    while (!finished && guard < 200) begin
      tick();
      guard++;
    end
    chk("finished_pulse", finished, 1);
    chk("busy_at_fin", busy, 1);
    e = sb.pop_front();
    chk("last_cycles", last_cycles, e.last);
    chk("runs_done", runs_done, e.runs);
    chk("timed_out", timed_out, e.tout);
    chk("min_cycles", min_cycles, e.mn);
    chk("max_cycles", max_cycles, e.mx);
    chk("total_cycles", total_cycles, e.tot);
    tick();
    chk("finished_drop", finished, 0);
    chk("busy_drop", busy, 0);
    chk("timed_out_hold", timed_out, e.tout);
  endtask

  initial begin
    int guard;
    reset = 1'b1; go = 1'b0; num_runs = 0; timeout_cycles = 0; done_port = 1'b0;
    s_go = 1'b0; s_num = 0; s_tmo = 0; s_done = 1'b0;
    tick();
    tick();
    chk("rst_dut_reset", dut_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_port, 0);
    chk("rst_finished", finished, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_runs_done", runs_done, 0);
    chk("rst_last", last_cycles, 0);
`ifdef HLS_RUN_SEQUENCER_STATS_EN
    chk("rst_min", min_cycles, 32'hFFFF_FFFF);
`else
    chk("rst_min", min_cycles, 0);
`endif
    chk("rst_max", max_cycles, 0);
    chk("rst_total", total_cycles, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_dut_reset", dut_reset, 0);

    // Single run, done four cycles after start.
    do_campaign(1, 0, 5, 0, 0, 1'b0);
    // Three runs with differing latencies.
    do_campaign(3, 0, 3, 7, 5, 1'b0);
    // Timeout with done never arriving, then done exactly at the limit.
    do_campaign(1, 10, 0, 0, 0, 1'b0);
    do_campaign(1, 10, 10, 0, 0, 1'b0);
    // Done during the start cycle, with a go raised while busy.
    do_campaign(1, 0, 1, 0, 0, 1'b1);

    // Empty campaign: one busy cycle, results untouched.
    go = 1'b1; num_runs = 0;
    tick();
    go = 1'b0;
    chk("zero_finished", finished, 1);
    chk("zero_busy", busy, 1);
    chk("zero_last_kept", last_cycles, 1);
    tick();
    chk("zero_busy_drop", busy, 0);
    chk("zero_finished_drop", finished, 0);

    // Reset in the middle of a WAIT.
    go = 1'b1; num_runs = 3; timeout_cycles = 0;
    tick();
    go = 1'b0;
    guard = 0;
    while (!start_port && guard < 100) begin
      tick();
      guard++;
    end
    chk("mid_start_seen", start_port, 1);
    tick(); tick(); tick();
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_start", start_port, 0);
    chk("mid_dut_reset", dut_reset, 1);
    chk("mid_finished", finished, 0);
    chk("mid_runs_done", runs_done, 0);
    reset = 1'b0;
    tick();
    chk("mid_dut_reset_rel", dut_reset, 0);
    chk("mid_busy_rel", busy, 0);

    // 4-bit counter saturates at 15.
    s_go = 1'b1; s_num = 1; s_tmo = 0;
    tick();
    s_go = 1'b0;
    guard = 0;
    while (!s_start && guard < 100) begin
      tick();
      guard++;
    end
    chk("sat_start_seen", s_start, 1);
    for (int k = 0; k < 20; k++) tick();
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    guard = 0;
    while (!s_finished && guard < 100) begin
      tick();
      guard++;
    end
    chk("sat_finished", s_finished, 1);
    chk("sat_last", s_last, 15);
    chk("sat_runs", s_runs, 1);
    chk("sat_timed_out", s_timed_out, 0);
`ifdef HLS_RUN_SEQUENCER_STATS_EN
    chk("sat_min", s_min, 15);
    chk("sat_max", s_max, 15);
    chk("sat_total", s_total, 15);
`else
    chk("sat_min", s_min, 0);
    chk("sat_max", s_max, 0);
    chk("sat_total", s_total, 0);
`endif
    chk("sat_busy", s_busy, 1);
    chk("sat_dut_reset", s_dut_reset, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
